angledist_feeder: RTL and testbench

Input-side front end for the angle-distance datapath. Accepts a serial element stream with a valid/ready handshake and deserialises it into vector pairs (vector 0, then vector 1, DIM elements each). Complete pairs are presented in parallel through a ping-pong double buffer to the distance unit. The block also emits a result-valid strobe and frame tag aligned with the distance unit's fixed output latency.

---
 rtl/angledist_pkg.sv | 14 +
 rtl/angledist_feeder_if.sv | 28 ++
 rtl/angledist_feeder_vec_pingpong_buf.sv | 57 +++++
 rtl/angledist_feeder.sv | 95 +++++++++
 tb/tb_angledist_feeder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/angledist_pkg.sv
// rtl/angledist_pkg.sv - shared types and sizes for the angle-distance feeder
package angledist_pkg;
   localparam int DIM      = 6;
   localparam int W        = 16;
   localparam int LAT      = 2;
   localparam int TAGW     = 8;
   localparam int PAIR_LEN = 2 * DIM;
   localparam int IDXW     = $clog2(PAIR_LEN);

   typedef logic [W-1:0]          T;
   typedef logic [TAGW-1:0]       tag_t;
   typedef logic [IDXW-1:0]       idx_t;
   typedef logic [PAIR_LEN*W-1:0] pair_vec_t;
endpackage

// File: rtl/angledist_feeder_if.sv
// rtl/angledist_feeder_if.sv - element stream in, pair/result out
interface angledist_feeder_if;
   import angledist_pkg::*;

   logic      in_valid_i;
   logic      in_ready_o;
   T          in_data_i;
   logic      in_last_i;
   logic      out_valid_o;
   logic      out_ready_i;
   pair_vec_t out_vec_o;
   tag_t      out_tag_o;
   logic      res_valid_o;
   tag_t      res_tag_o;
   logic      err_o;

   modport slave (
      input  in_valid_i, in_data_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_vec_o, out_tag_o,
             res_valid_o, res_tag_o, err_o
   );

   modport master (
      output in_valid_i, in_data_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_vec_o, out_tag_o,
             res_valid_o, res_tag_o, err_o
   );
endinterface

// File: rtl/angledist_feeder_vec_pingpong_buf.sv
// rtl/angledist_feeder_vec_pingpong_buf.sv - two pair buffers with full flags and ping-pong selects
module vec_pingpong_buf
   import angledist_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      wr_en,
   input  idx_t      wr_idx,
   input  T          wr_data,
   input  logic      wr_commit,
   input  tag_t      wr_tag,
   input  logic      rd_take,
   output logic      wr_full,
   output logic      rd_full,
   output pair_vec_t rd_vec,
   output tag_t      rd_tag
);
   T           mem [2][PAIR_LEN];
   tag_t       tag [2];
   logic [1:0] full;
   logic       wr_sel;
   logic       rd_sel;

   // A commit and a take never hit the same buffer: writing needs it empty, taking needs it full.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < PAIR_LEN; i++) mem[b][i] <= '0;
            tag[b] <= '0;
         end
         full   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
      end else begin
         if (wr_en) mem[wr_sel][wr_idx] <= wr_data;
         if (wr_commit) begin
            full[wr_sel] <= 1'b1;
            tag[wr_sel]  <= wr_tag;
            wr_sel       <= ~wr_sel;
         end
         if (rd_take) begin
            full[rd_sel] <= 1'b0;
            rd_sel       <= ~rd_sel;
         end
      end
   end

   // Present the read-side buffer as one flat pair vector.
   always_comb begin
      rd_vec = '0;
      for (int i = 0; i < PAIR_LEN; i++) rd_vec[i*W +: W] = mem[rd_sel][i];
   end

   assign rd_tag  = tag[rd_sel];
   assign wr_full = full[wr_sel];
   assign rd_full = full[rd_sel];
endmodule

// File: rtl/angledist_feeder.sv
// rtl/angledist_feeder.sv - deserialises element stream into vector pairs and aligns result strobes
module angledist_feeder
   import angledist_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   angledist_feeder_if.slave bus
);
   localparam idx_t LAST_IDX = idx_t'(PAIR_LEN - 1);

   idx_t      widx;
   tag_t      tag_cnt;
   logic      err;
   logic      wr_full;
   logic      rd_full;
   logic      accept;
   logic      at_last;
   logic      commit;
   logic      fire;
   pair_vec_t rd_vec;
   tag_t      rd_tag;
   logic      dl_valid [LAT];
   tag_t      dl_tag   [LAT];

   // in_ready depends only on registered full flags, never on out_ready.
   assign accept  = bus.in_valid_i && !wr_full;
   assign at_last = (widx == LAST_IDX);
   assign commit  = accept && at_last;
   assign fire    = rd_full && bus.out_ready_i;

   vec_pingpong_buf u_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en     (accept),
      .wr_idx    (widx),
      .wr_data   (bus.in_data_i),
      .wr_commit (commit),
      .wr_tag    (tag_cnt),
      .rd_take   (fire),
      .wr_full   (wr_full),
      .rd_full   (rd_full),
      .rd_vec    (rd_vec),
      .rd_tag    (rd_tag)
   );

   // Framing: element index, tag counter and framing-error pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         widx    <= '0;
         tag_cnt <= '0;
         err     <= 1'b0;
      end else begin
         err <= 1'b0;
         if (accept) begin
            if (at_last) begin
               // A missing last still completes the frame but is flagged.
               widx    <= '0;
               tag_cnt <= tag_cnt + 1'b1;
               err     <= !bus.in_last_i;
            end else if (bus.in_last_i) begin
               // Early last: drop the partial frame without consuming a tag.
               widx <= '0;
               err  <= 1'b1;
            end else begin
               widx <= widx + 1'b1;
            end
         end
      end
   end

   // Result delay line matching the distance unit latency.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LAT; i++) begin
            dl_valid[i] <= 1'b0;
            dl_tag[i]   <= '0;
         end
      end else begin
         dl_valid[0] <= fire;
         dl_tag[0]   <= fire ? rd_tag : '0;
         for (int i = 1; i < LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_tag[i]   <= dl_tag[i-1];
         end
      end
   end

   assign bus.in_ready_o  = !wr_full;
   assign bus.out_valid_o = rd_full;
   assign bus.out_vec_o   = rd_vec;
   assign bus.out_tag_o   = rd_tag;
   assign bus.res_valid_o = dl_valid[LAT-1];
   assign bus.res_tag_o   = dl_tag[LAT-1];
   assign bus.err_o       = err;
endmodule

// File: tb/tb_angledist_feeder.sv
// tb/tb_angledist_feeder.sv - scoreboard bench for angledist_feeder
module tb_angledist_feeder;
   import angledist_pkg::*;

   localparam int VW = PAIR_LEN * W;

   typedef struct {
      logic [VW-1:0]   vec;
      logic [TAGW-1:0] tag;
   } pair_t;

   typedef struct {
      int              cyc;
      logic [TAGW-1:0] tag;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   angledist_feeder_if bus();

   angledist_feeder dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests    = 0;
   int fails    = 0;
   int cyc      = 0;
   int err_seen = 0;
   int stalls   = 0;
   int e0;

   pair_t           pair_q[$];
   res_t            res_q[$];
   logic [TAGW-1:0] exp_tag;
   pair_t           mp;
   res_t            mr;

   task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: pops expected pairs on each out handshake and checks result timing.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.err_o) err_seen++;
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (pair_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pair: got tag %0d, expected no pair", bus.out_tag_o);
            end else begin
               mp = pair_q.pop_front();
               chk("pair_vec", bus.out_vec_o, mp.vec);
               chk("pair_tag", VW'(bus.out_tag_o), VW'(mp.tag));
               res_q.push_back('{cyc + LAT, mp.tag});
            end
         end
         if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
            mr = res_q.pop_front();
            chk("res_valid", VW'(bus.res_valid_o), VW'(1));
            chk("res_tag", VW'(bus.res_tag_o), VW'(mr.tag));
         end else if (bus.res_valid_o) begin
            tests++;
            fails++;
            $display("FAIL unexpected_res: got res_valid 1 tag %0d, expected 0", bus.res_tag_o);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
      bus.in_data_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_tag = '0;
      pair_q.delete();
      res_q.delete();
   endtask

   // Drive one element; returns 1 time unit after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic last);
      int n;
      n = 0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = d;
      bus.in_last_i  = last;
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         stalls++;
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
   endtask

   task automatic send_pair(input logic [W-1:0] base, input bit with_last);
      pair_t p;
      for (int k = 0; k < PAIR_LEN; k++) p.vec[k*W +: W] = base + W'(k);
      p.tag = exp_tag;
      exp_tag++;
      pair_q.push_back(p);
      for (int k = 0; k < PAIR_LEN; k++) send(base + W'(k), with_last && (k == PAIR_LEN - 1));
   endtask

   task automatic chk_drained(input string name);
      chk(name, VW'(pair_q.size() + res_q.size()), VW'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.in_last_i   = 1'b0;
      bus.out_ready_i = 1'b1;
      exp_tag         = '0;
      rst             = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_in_ready",  VW'(bus.in_ready_o),  VW'(1));
      chk("rst_out_valid", VW'(bus.out_valid_o), VW'(0));
      chk("rst_out_vec",   bus.out_vec_o,        VW'(0));
      chk("rst_out_tag",   VW'(bus.out_tag_o),   VW'(0));
      chk("rst_res_valid", VW'(bus.res_valid_o), VW'(0));
      chk("rst_res_tag",   VW'(bus.res_tag_o),   VW'(0));
      chk("rst_err",       VW'(bus.err_o),       VW'(0));

      // Single pair 1..12.
      do_reset();
      send_pair(16'd1, 1'b1);
      chk("first_valid_latency", VW'(bus.out_valid_o), VW'(1));
      idle(6);
      chk_drained("t1_drained");

      // Back-pressure: three pairs, two buffered, third stalls until release.
      do_reset();
      bus.out_ready_i = 1'b0;
      fork
         begin
            send_pair(16'h0100, 1'b1);
            send_pair(16'h0200, 1'b1);
            send_pair(16'h0300, 1'b1);
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            chk("bp_in_ready_low",  VW'(bus.in_ready_o),  VW'(0));
            chk("bp_out_valid_high", VW'(bus.out_valid_o), VW'(1));
            bus.out_ready_i = 1'b1;
         end
      join
      idle(8);
      chk_drained("t2_drained");

      // Early last on element 5.
      do_reset();
      e0 = err_seen;
      for (int k = 0; k < 5; k++) send(16'h0050 + 16'(k), k == 4);
      idle(2);
      chk("early_err_count", VW'(err_seen - e0), VW'(1));
      chk("early_no_pair",   VW'(bus.out_valid_o), VW'(0));
      send_pair(16'h0600, 1'b1);
      idle(5);
      chk("early_err_once", VW'(err_seen - e0), VW'(1));
      chk_drained("t3_drained");

      // Missing last: frame still emitted, one error.
      e0 = err_seen;
      send_pair(16'h0700, 1'b0);
      idle(5);
      chk("missing_err_count", VW'(err_seen - e0), VW'(1));
      chk_drained("t4_drained");

      // 260 back-to-back frames, tags wrap, no stalls.
      do_reset();
      stalls = 0;
      for (int f = 0; f < 260; f++) send_pair(W'(f * 16), 1'b1);
      idle(6);
      chk("stream_stalls", VW'(stalls), VW'(0));
      chk_drained("t5_drained");

      // Asynchronous reset mid-frame with one full buffer.
      do_reset();
      bus.out_ready_i = 1'b0;
      send_pair(16'h0900, 1'b1);
      for (int k = 0; k < 4; k++) send(16'h0A00 + 16'(k), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready",  VW'(bus.in_ready_o),  VW'(1));
      chk("arst_out_valid", VW'(bus.out_valid_o), VW'(0));
      chk("arst_out_vec",   bus.out_vec_o,        VW'(0));
      chk("arst_out_tag",   VW'(bus.out_tag_o),   VW'(0));
      chk("arst_res_valid", VW'(bus.res_valid_o), VW'(0));
      chk("arst_err",       VW'(bus.err_o),       VW'(0));
      pair_q.delete();
      res_q.delete();
      exp_tag = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready_i = 1'b1;
      idle(10);
      chk("arst_no_stale", VW'(bus.out_valid_o), VW'(0));
      send_pair(16'h0B00, 1'b1);
      idle(6);
      chk_drained("t6_drained");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
